// File: rtl/dump_ctrl_pkg.sv
// Shared types and constants for the data-memory dump controller.
// Optional feature macro: DUMP_CHECKSUM_EN (adds a trailing XOR checksum beat).
package dump_ctrl_pkg;

    typedef enum logic [2:0] {IDLE, FREEZE, SCAN, SEND, DONE} dump_state_t;

    localparam int WORD_BYTES_LOG2 = 3;
    localparam int DEF_DM_WORDS    = 32;
    localparam int DEF_IDX_W       = $clog2(DEF_DM_WORDS);

    // Index tag carried by the checksum beat.
    localparam logic [DEF_IDX_W-1:0] CKSUM_IDX = '1;

endpackage

// File: rtl/dm_port_mux.sv
// Steers the single DM port to the CPU or to the dump engine's word address.
// Combinational, zero latency; no backpressure (dump engine never writes).
module dm_port_mux
    import dump_ctrl_pkg::*;
#(
    parameter int N  = 64,
    parameter int IW = DEF_IDX_W
) (
    input  logic          dump_own,
    input  logic [IW-1:0] idx,
    input  logic [N-1:0]  cpu_addr,
    input  logic [N-1:0]  cpu_wdata,
    input  logic          cpu_we,
    output logic [N-1:0]  dm_addr,
    output logic [N-1:0]  dm_wdata,
    output logic          dm_we
);

    always_comb begin
        dm_addr  = cpu_addr;
        dm_wdata = cpu_wdata;
        dm_we    = cpu_we;
        if (dump_own) begin
            dm_addr  = N'(idx) << WORD_BYTES_LOG2;
            dm_wdata = '0;
            dm_we    = 1'b0;
        end
    end

endmodule

// File: rtl/dmem_dump_ctrl.sv
// Freezes the core and streams every DM word out over valid/ready; 2 cycles/word min, held on !dout_ready.
// Optional feature macro: DUMP_CHECKSUM_EN appends one XOR checksum beat tagged with an all-ones index.
module dmem_dump_ctrl
    import dump_ctrl_pkg::*;
#(
    parameter int N        = 64,
    parameter int DM_WORDS = DEF_DM_WORDS
) (
    input  logic                        CLOCK_50,
    input  logic                        reset,
    input  logic                        dump_req,
    input  logic [N-1:0]                cpu_addr,
    input  logic [N-1:0]                cpu_wdata,
    input  logic                        cpu_we,
    output logic [N-1:0]                cpu_rdata,
    output logic                        cpu_stall,
    output logic [N-1:0]                dm_addr,
    output logic [N-1:0]                dm_wdata,
    output logic                        dm_we,
    input  logic [N-1:0]                dm_rdata,
    output logic [N-1:0]                dout_data,
    output logic [$clog2(DM_WORDS)-1:0] dout_idx,
    output logic                        dout_valid,
    input  logic                        dout_ready,
    output logic                        busy,
    output logic                        done
);

    localparam int IW = $clog2(DM_WORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(DM_WORDS - 1);

    dump_state_t   state;
    logic [IW-1:0] idx;
    logic          dump_req_q;
`ifdef DUMP_CHECKSUM_EN
    logic [N-1:0]  cksum;
    logic          cksum_beat;
`endif

    assign busy      = (state != IDLE);
    assign cpu_rdata = dm_rdata;

    dm_port_mux #(.N(N), .IW(IW)) u_mux (
        .dump_own  (busy),
        .idx       (idx),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_we     (dm_we)
    );

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            dump_req_q <= 1'b0;
            dout_data  <= '0;
            dout_idx   <= '0;
            dout_valid <= 1'b0;
            done       <= 1'b0;
            cpu_stall  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            cksum      <= '0;
            cksum_beat <= 1'b0;
`endif
        end else begin
            dump_req_q <= dump_req;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (dump_req && !dump_req_q) begin
                        state     <= FREEZE;
                        cpu_stall <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
                        cksum      <= '0;
                        cksum_beat <= 1'b0;
`endif
                    end
                end
                FREEZE: state <= SCAN;
                SCAN: begin
                    dout_data  <= dm_rdata;
                    dout_idx   <= idx;
                    dout_valid <= 1'b1;
                    state      <= SEND;
                end
                SEND: begin
                    if (dout_ready) begin
`ifdef DUMP_CHECKSUM_EN
                        if (cksum_beat) begin
                            dout_valid <= 1'b0;
                            done       <= 1'b1;
                            state      <= DONE;
                        end else begin
                            cksum <= cksum ^ dout_data;
                            if (idx == LAST_IDX) begin
                                // Stay in SEND: the checksum beat reuses the output register.
                                dout_data  <= cksum ^ dout_data;
                                dout_idx   <= '1;
                                cksum_beat <= 1'b1;
                            end else begin
                                dout_valid <= 1'b0;
                                idx        <= idx + 1'b1;
                                state      <= SCAN;
                            end
                        end
`else
                        dout_valid <= 1'b0;
                        if (idx == LAST_IDX) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= SCAN;
                        end
`endif
                    end
                end
                DONE: begin
                    idx       <= '0;
                    cpu_stall <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_dump_ctrl.sv
// Scoreboard bench for dmem_dump_ctrl: expected beats queued by stimulus, popped by a negedge monitor.
module tb_dmem_dump_ctrl;
    import dump_ctrl_pkg::*;

    localparam int N  = 64;
    localparam int W  = 32;
    localparam int IW = 5;
`ifdef DUMP_CHECKSUM_EN
    localparam int EXP_CYC = 67;
`else
    localparam int EXP_CYC = 66;
`endif

    logic          CLOCK_50 = 1'b0;
    logic          reset = 1'b1;
    logic          dump_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic          dout_ready = 1'b0;
    logic [N-1:0]  cpu_addr = '0;
    logic [N-1:0]  cpu_wdata = '0;
    logic [N-1:0]  cpu_rdata, dm_addr, dm_wdata, dm_rdata, dout_data;
    logic          cpu_stall, dm_we, dout_valid, busy, done;
    logic [IW-1:0] dout_idx;

    logic [N-1:0]  mem [0:W-1];

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [N-1:0]  data;
    } beat_t;
    beat_t exp_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    bit toggle_ready = 1'b0;
    int ph = 0;

    logic          prev_hold = 1'b0;
    logic [N-1:0]  prev_data = '0;
    logic [IW-1:0] prev_idx = '0;

    dmem_dump_ctrl #(.N(N), .DM_WORDS(W)) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .dump_req   (dump_req),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_we     (cpu_we),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_we      (dm_we),
        .dm_rdata   (dm_rdata),
        .dout_data  (dout_data),
        .dout_idx   (dout_idx),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Data memory model: combinational read, write on clock when addressed in range.
    assign dm_rdata = mem[dm_addr[7:3]];
    always @(posedge CLOCK_50) begin
        if (dm_we && dm_addr < 64'h100) mem[dm_addr[7:3]] = dm_wdata;
    end

    always @(posedge CLOCK_50) begin
        if (toggle_ready) begin
            #1;
            dout_ready = (ph == 0);
            ph = (ph + 1) % 4;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor
    always @(negedge CLOCK_50) begin
        beat_t b;
        if (!reset) begin
            if (prev_hold) begin
                check("hold_data", dout_data, prev_data);
                check("hold_idx", 64'(dout_idx), 64'(prev_idx));
            end
            if (busy) begin
                check("dm_we_busy", 64'(dm_we), 64'd0);
                check("stall_busy", 64'(cpu_stall), 64'd1);
            end else begin
                check("stall_idle", 64'(cpu_stall), 64'd0);
            end
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL beat_unexpected: got idx %0d data %h expected no beat", dout_idx, dout_data);
                end else begin
                    b = exp_q.pop_front();
                    check("beat_idx", 64'(dout_idx), 64'(b.idx));
                    check("beat_data", dout_data, b.data);
                end
            end
            if (done) done_cnt++;
        end
        prev_hold = !reset && dout_valid && !dout_ready;
        prev_data = dout_data;
        prev_idx  = dout_idx;
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic push_dump(input bit auto_ck);
        logic [N-1:0] x;
        x = '0;
        for (int i = 0; i < W; i++) begin
            exp_q.push_back(beat_t'{IW'(i), mem[i]});
            x = x ^ mem[i];
        end
`ifdef DUMP_CHECKSUM_EN
        if (auto_ck) exp_q.push_back(beat_t'{CKSUM_IDX, x});
`endif
    endtask

    task automatic run_dump(output int n);
        dump_req = 1'b1;
        @(negedge CLOCK_50);
        n = 0;
        while (!done && n < 1000) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL dump_timeout: got no done after %0d cycles expected done", n);
        end
        tick();
    endtask

    initial begin
        int n;
        int dc;

        // Reset with a CPU store presented: port must pass through.
        cpu_we = 1'b1;
        cpu_addr = 64'h10;
        cpu_wdata = 64'hAB;
        reset = 1'b1;
        tick();
        tick();
        @(negedge CLOCK_50);
        check("rst_dm_we", 64'(dm_we), 64'd1);
        check("rst_dm_addr", dm_addr, 64'h10);
        check("rst_dm_wdata", dm_wdata, 64'hAB);
        check("rst_cpu_rdata", cpu_rdata, 64'hAB);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(dout_valid), 64'd0);
        check("rst_stall", 64'(cpu_stall), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dout", dout_data, 64'd0);
        reset = 1'b0;
        cpu_we = 1'b0;
        tick();

        // Full dump with ready held high.
        for (int i = 0; i < W; i++) mem[i] = 64'h100 + 64'(i);
        push_dump(1'b1);
        dout_ready = 1'b1;
        run_dump(n);
        check("done_latency", 64'(n), 64'(EXP_CYC));
        check("q_empty_1", 64'(exp_q.size()), 64'd0);

        // dump_req held high: no retrigger.
        repeat (10) tick();
        check("hold_no_busy", 64'(busy), 64'd0);
        check("hold_done_cnt", 64'(done_cnt), 64'd1);

        // Drop and raise: second dump, ready 1-of-4, core keeps trying to store.
        dump_req = 1'b0;
        tick();
        for (int i = 0; i < W; i++) mem[i] = (64'(i) * 64'h0101_0101) ^ 64'hA5;
        push_dump(1'b1);
        cpu_we = 1'b1;
        cpu_addr = 64'h800;
        cpu_wdata = 64'hDEAD;
        ph = 0;
        toggle_ready = 1'b1;
        run_dump(n);
        toggle_ready = 1'b0;
        tick();
        dout_ready = 1'b1;
        cpu_we = 1'b0;
        check("q_empty_2", 64'(exp_q.size()), 64'd0);
        check("done_cnt_2", 64'(done_cnt), 64'd2);

        // Reset in the middle of the beat with idx 5.
        dump_req = 1'b0;
        tick();
        push_dump(1'b1);
        dump_req = 1'b1;
        @(negedge CLOCK_50);
        n = 0;
        while (!(dout_valid && dout_idx == 5) && n < 200) begin
            @(negedge CLOCK_50);
            n++;
        end
        check("reach_idx5", 64'(dout_valid && dout_idx == 5), 64'd1);
        dc = done_cnt;
        reset = 1'b1;
        @(negedge CLOCK_50);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_stall", 64'(cpu_stall), 64'd0);
        check("mid_rst_valid", 64'(dout_valid), 64'd0);
        exp_q.delete();
        reset = 1'b0;
        dump_req = 1'b0;
        repeat (5) tick();
        check("mid_rst_no_done", 64'(done_cnt), 64'(dc));

`ifdef DUMP_CHECKSUM_EN
        // Checksum: 31 words of 0x1 and one 0x3 XOR to 0x2.
        for (int i = 0; i < W; i++) mem[i] = 64'h1;
        mem[3] = 64'h3;
        push_dump(1'b0);
        exp_q.push_back(beat_t'{5'd31, 64'h2});
        run_dump(n);
        check("ck_latency", 64'(n), 64'd67);
        check("q_empty_ck", 64'(exp_q.size()), 64'd0);
`endif

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
